// File: rtl/exu_commit_mc.sv
// ---------------------------------------------------------------------------
// exu_commit_mc
//   Multi-channel in-order commit stage. Up to CMT_CH instructions retire per
//   cycle, with channel 0 the oldest. A committed branch mispredict, or an
//   illegal instruction when TRAP_EN=1, causes a flush. The flush target and
//   its cause are registered. The FSM then holds pipe_flush_req high until the
//   IFU acknowledges it. cmt_cnt counts retired instructions. Instructions
//   that trap are not counted.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   alu_cmt_i_valid       per-channel commit request
//   alu_cmt_i_ready       per-channel commit accept (in-order, stalls on flush)
//   alu_cmt_i_imm         branch offsets, channel i at [i*XLEN +: XLEN]
//   alu_cmt_i_bjp         branch/jump flag
//   alu_cmt_i_bjp_prdt    predicted taken
//   alu_cmt_i_bjp_rslv    resolved taken
//   alu_cmt_i_pc          instruction PCs, channel i at [i*PC_SIZE +: PC_SIZE]
//   alu_cmt_i_ilegl       illegal instruction flag
//   nonflush_cmt_ena      channel committed without causing a flush
//   pipe_flush_req        registered flush request to IFU
//   pipe_flush_ack        IFU flush accept
//   pipe_flush_add_op1/2  flush target addends (target = op1 + op2)
//   flush_cause           0 = branch mispredict, 1 = illegal-instruction trap
//   flush_pulse           flush handshake completes this cycle
//   cmt_cnt               retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module exu_commit_mc #(
    parameter int                  CMT_CH   = 2,
    parameter int                  XLEN     = 32,
    parameter int                  PC_SIZE  = 32,
    parameter int                  CNT_W    = 64,
    parameter int                  TRAP_EN  = 1,
    parameter logic [PC_SIZE-1:0]  TRAP_VEC = 'h80
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CMT_CH-1:0]         alu_cmt_i_valid,
    output logic [CMT_CH-1:0]         alu_cmt_i_ready,
    input  logic [CMT_CH*XLEN-1:0]    alu_cmt_i_imm,
    input  logic [CMT_CH-1:0]         alu_cmt_i_bjp,
    input  logic [CMT_CH-1:0]         alu_cmt_i_bjp_prdt,
    input  logic [CMT_CH-1:0]         alu_cmt_i_bjp_rslv,
    input  logic [CMT_CH*PC_SIZE-1:0] alu_cmt_i_pc,
    input  logic [CMT_CH-1:0]         alu_cmt_i_ilegl,
    output logic [CMT_CH-1:0]         nonflush_cmt_ena,
    output logic                      pipe_flush_req,
    input  logic                      pipe_flush_ack,
    output logic [PC_SIZE-1:0]        pipe_flush_add_op1,
    output logic [PC_SIZE-1:0]        pipe_flush_add_op2,
    output logic                      flush_cause,
    output logic                      flush_pulse,
    output logic [CNT_W-1:0]          cmt_cnt
);

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t              state_q, state_d;
    logic [CMT_CH-1:0]   trap_ch;      // channel traps as illegal
    logic [CMT_CH-1:0]   flush_ch;     // channel would cause a flush
    logic [CMT_CH-1:0]   commit;
    logic                in_order;
    logic                flush_hit;
    logic [PC_SIZE-1:0]  op1_d, op2_d;
    logic                cause_d;
    logic [CNT_W-1:0]    cnt_inc;

    assign pipe_flush_req = (state_q == S_FLUSH);

    // Flush classification per channel.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
        trap_ch  = '0;
        flush_ch = '0;
        for (int i = 0; i < CMT_CH; i++) begin
            trap_ch[i]  = (TRAP_EN != 0) && alu_cmt_i_ilegl[i];
            flush_ch[i] = (alu_cmt_i_bjp[i] &&
                           (alu_cmt_i_bjp_prdt[i] != alu_cmt_i_bjp_rslv[i])) ||
                          trap_ch[i];
        end
    end

    // In-order acceptance. A channel is ready only when every older channel
    // is valid and none of them flushes. Nothing is accepted in FLUSH or
    // during reset.
    always_comb begin
        alu_cmt_i_ready = '0;
        in_order        = !rst && (state_q == S_IDLE);
        for (int i = 0; i < CMT_CH; i++) begin
            in_order           = in_order && alu_cmt_i_valid[i];
            alu_cmt_i_ready[i] = in_order;
            in_order           = in_order && !flush_ch[i];
        end
    end

    assign commit           = alu_cmt_i_valid & alu_cmt_i_ready;
    assign nonflush_cmt_ena = commit & ~flush_ch & {CMT_CH{~pipe_flush_req}};
    assign flush_pulse      = pipe_flush_req & pipe_flush_ack & ~rst;

    // Flush target from the lowest committed flush-causing channel. The ready
    // chain guarantees at most one such channel per cycle. The first-hit guard
    // keeps that intent explicit.
    always_comb begin
        flush_hit = 1'b0;
        op1_d     = pipe_flush_add_op1;
        op2_d     = pipe_flush_add_op2;
        cause_d   = flush_cause;
        cnt_inc   = '0;
        for (int i = 0; i < CMT_CH; i++) begin
            cnt_inc = cnt_inc + CNT_W'(commit[i] & ~trap_ch[i]);
            if (commit[i] && flush_ch[i] && !flush_hit) begin
                flush_hit = 1'b1;
                if (trap_ch[i]) begin
                    op1_d   = TRAP_VEC;
                    op2_d   = '0;
                    cause_d = 1'b1;
                end else if (alu_cmt_i_bjp_rslv[i]) begin
                    op1_d   = alu_cmt_i_pc[i*PC_SIZE +: PC_SIZE];
                    op2_d   = PC_SIZE'($signed(alu_cmt_i_imm[i*XLEN +: XLEN]));
                    cause_d = 1'b0;
                end else begin
                    op1_d   = alu_cmt_i_pc[i*PC_SIZE +: PC_SIZE];
                    op2_d   = PC_SIZE'(4);
                    cause_d = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (flush_hit)   state_d = S_FLUSH;
            S_FLUSH: if (flush_pulse) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
        if (rst) begin
            state_q            <= S_IDLE;
            pipe_flush_add_op1 <= '0;
            pipe_flush_add_op2 <= '0;
            flush_cause        <= 1'b0;
            cmt_cnt            <= '0;
        end else begin
            state_q <= state_d;
            cmt_cnt <= cmt_cnt + cnt_inc;
            if (flush_hit) begin
                pipe_flush_add_op1 <= op1_d;
                pipe_flush_add_op2 <= op2_d;
                flush_cause        <= cause_d;
            end
        end
    end

endmodule

// File: doc/exu_commit_mc.md
EXU_COMMIT_MC -- requirements
Module: exu_commit_mc

Interface
REQ-001 The block SHALL provide parameter CMT_CH, default 2: number of in-order commit channels; channel 0 is oldest.
REQ-002 The block SHALL provide parameter XLEN, default 32: immediate width.
REQ-003 The block SHALL provide parameter PC_SIZE, default 32: PC and flush-operand width.
REQ-004 The block SHALL provide parameter CNT_W, default 64: retire-counter width.
REQ-005 The block SHALL provide parameter TRAP_EN, default 1: when 1, illegal instructions cause a trap flush.
REQ-006 The block SHALL provide parameter TRAP_VEC, default 'h80: trap target PC.
REQ-007 The block SHALL have one clock and a synchronous, active-high reset, with ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alu_cmt_i_valid  in  CMT_CH  per-channel commit request
- alu_cmt_i_ready  out  CMT_CH  per-channel commit accept
- alu_cmt_i_imm  in  CMT_CH*XLEN  branch offset; channel i at bits [i*XLEN +: XLEN]
- alu_cmt_i_bjp  in  CMT_CH  instruction is a branch/jump
- alu_cmt_i_bjp_prdt  in  CMT_CH  predicted taken
- alu_cmt_i_bjp_rslv  in  CMT_CH  resolved taken
- alu_cmt_i_pc  in  CMT_CH*PC_SIZE  instruction PC
- alu_cmt_i_ilegl  in  CMT_CH  illegal instruction
- nonflush_cmt_ena  out  CMT_CH  channel committed without causing a flush
- pipe_flush_req  out  1  registered flush request to IFU
- pipe_flush_ack  in  1  IFU flush accept
- pipe_flush_add_op1  out  PC_SIZE  flush-target addend 1
- pipe_flush_add_op2  out  PC_SIZE  flush-target addend 2
- flush_cause  out  1  0 = branch mispredict, 1 = illegal-instruction trap
- flush_pulse  out  1  flush handshake completed this cycle
- cmt_cnt  out  CNT_W  retired-instruction count

Function
REQ-008 The block SHALL implement a two-state FSM, IDLE and FLUSH; reset enters IDLE.
REQ-009 A channel SHALL be flush-causing when (bjp & (prdt != rslv)) | (TRAP_EN & ilegl).
REQ-010 In IDLE, alu_cmt_i_ready[i] SHALL be 1 only when valid[0..i] are all 1 and no channel j<i is flush-causing; no channel is accepted out of order.
REQ-011 A channel SHALL commit in a cycle when valid[i] & ready[i].
REQ-012 nonflush_cmt_ena[i] SHALL equal (commit of channel i) & ~(channel i flush-causing) & ~pipe_flush_req.
REQ-013 On commit of the lowest flush-causing channel f, the block SHALL register its target and cause, and enter FLUSH on the next cycle.
REQ-014 The registered flush target for channel f SHALL be:
- illegal with TRAP_EN=1: op1=TRAP_VEC, op2=0, cause=1; this takes priority over a mispredict on the same channel.
- mispredict with rslv=1: op1=pc, op2=imm sign-extended or truncated to PC_SIZE, cause=0.
- mispredict with rslv=0: op1=pc, op2=4, cause=0.
REQ-015 In FLUSH, pipe_flush_req SHALL be 1, all ready bits SHALL be 0, and op1, op2 and flush_cause SHALL stay stable until acknowledged.
REQ-016 flush_pulse SHALL equal pipe_flush_req & pipe_flush_ack, combinationally.
REQ-017 On flush_pulse the FSM SHALL return to IDLE, and pipe_flush_req SHALL be 0 from the next cycle.
REQ-018 An ack received in IDLE SHALL be ignored.
REQ-019 An ack arriving in the same cycle that FLUSH is entered SHALL NOT be honoured until pipe_flush_req is visible.
REQ-020 cmt_cnt SHALL increment each cycle by the number of committed channels, excluding a channel committed as an illegal trap and including a mispredicted branch.
REQ-021 cmt_cnt SHALL wrap modulo 2^CNT_W.
REQ-022 When TRAP_EN=0, ilegl SHALL be ignored and the instruction committed normally.
REQ-023 pipe_flush_add_op1, pipe_flush_add_op2 and flush_cause SHALL hold their last registered values outside FLUSH.

Reset
REQ-024 While rst=1 at a clk edge, the block SHALL clear:
- FSM to IDLE.
- pipe_flush_req, flush_cause, op1, op2 and cmt_cnt to 0.
REQ-025 A reset in FLUSH SHALL abandon the pending flush with no flush_pulse after the reset.
REQ-026 During reset, ready, nonflush_cmt_ena and flush_pulse SHALL be 0.

Verification
REQ-027 Dual commit: valid=2'b11, no branch, no illegal -> ready=2'b11, nonflush_cmt_ena=2'b11, cmt_cnt 0 -> 2 next cycle.
REQ-028 In-order hole: valid=2'b10 -> ready=2'b00, cmt_cnt unchanged.
REQ-029 Mispredict on channel 0, then ack:
- stimulus: ch0 bjp=1, prdt=0, rslv=1, pc='h100, imm='h20; ch1 valid.
- ready=2'b01, nonflush_cmt_ena=0, cmt_cnt +1.
- next cycle: req=1, op1='h100, op2='h20, cause=0.
- hold ack=0 for 3 cycles: req and operands stable, ready=0.
- ack=1: flush_pulse=1 for one cycle, then req=0.
REQ-030 Illegal trap on channel 1:
- stimulus: ch0 normal, ch1 ilegl=1, pc='h204.
- ready=2'b11, nonflush_cmt_ena=2'b01, cmt_cnt +1.
- next cycle: op1='h80, op2=0, cause=1.
REQ-031 Not-taken recovery: prdt=1, rslv=0, pc='h40 -> op1='h40, op2=4.
REQ-032 Reset and wrap:
- rst=1 while req=1 -> req=0 next cycle, no flush_pulse.
- cmt_cnt at all-ones plus one commit -> 0.
